// File: rtl/ahb_gpio_parity.sv
//------------------------------------------------------------------------------
// Module      : ahb_gpio_parity
// Description : AHB-Lite zero-wait-state GPIO slave, 16 data bits plus parity
//               generation (output mode) or parity checking (input mode).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ahb_gpio_parity (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [16:0] GPIOIN,
    input  logic        PARITYSEL,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [16:0] GPIOOUT,
    output logic        PARITYERR
);

    localparam logic [7:0] c_ADDR_DATA = 8'h00;
    localparam logic [7:0] c_ADDR_DIR  = 8'h04;

    logic [7:0]  r_addr_q,    w_addr_d;
    logic        r_write_q,   w_write_d;
    logic        r_valid_q,   w_valid_d;
    logic        r_dir_q,     w_dir_d;
    logic [15:0] r_datain_q,  w_datain_d;
    logic [16:0] r_gpioout_q, w_gpioout_d;
    logic        r_perr_q,    w_perr_d;

    logic        w_wr_phase;
    logic        w_rd_phase;
    logic        w_out_par;
    logic        w_in_par;

    // Bits outside the decoded range are intentionally ignored.
    logic        w_unused_ok;
    assign w_unused_ok = &{1'b0, HADDR[31:8], HWDATA[31:16], HTRANS[0]};

    assign w_wr_phase = r_valid_q &  r_write_q;
    assign w_rd_phase = r_valid_q & ~r_write_q;

    // Even parity makes the total number of ones even; odd inverts it.
    assign w_out_par  = PARITYSEL ? ~^HWDATA[15:0] : ^HWDATA[15:0];
    assign w_in_par   = PARITYSEL ? ~^GPIOIN[15:0] : ^GPIOIN[15:0];

    always_comb begin
        w_valid_d   = HSEL & HREADY & HTRANS[1];
        w_addr_d    = w_valid_d ? HADDR[7:0] : r_addr_q;
        w_write_d   = w_valid_d ? HWRITE     : r_write_q;
        w_dir_d     = r_dir_q;
        w_gpioout_d = r_gpioout_q;
        w_datain_d  = r_datain_q;
        w_perr_d    = 1'b0;

        if (w_wr_phase && (r_addr_q == c_ADDR_DIR)) begin
            w_dir_d = HWDATA[0];
        end
        if (w_wr_phase && (r_addr_q == c_ADDR_DATA) && r_dir_q) begin
            w_gpioout_d = {w_out_par, HWDATA[15:0]};
        end
        if (!r_dir_q) begin
            w_datain_d = GPIOIN[15:0];
            w_perr_d   = (GPIOIN[16] != w_in_par);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            r_addr_q    <= 8'h00;
            r_write_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            r_dir_q     <= 1'b0;
            r_datain_q  <= 16'h0000;
            r_gpioout_q <= 17'h00000;
            r_perr_q    <= 1'b0;
        end else begin
            r_addr_q    <= w_addr_d;
            r_write_q   <= w_write_d;
            r_valid_q   <= w_valid_d;
            r_dir_q     <= w_dir_d;
            r_datain_q  <= w_datain_d;
            r_gpioout_q <= w_gpioout_d;
            r_perr_q    <= w_perr_d;
        end
    end

    always_comb begin
        HRDATA = 32'h0000_0000;
        if (w_rd_phase) begin
            case (r_addr_q)
                c_ADDR_DATA: HRDATA = {16'h0000, (r_dir_q ? r_gpioout_q[15:0] : r_datain_q)};
                c_ADDR_DIR:  HRDATA = {31'h0, r_dir_q};
                default:     HRDATA = 32'h0000_0000;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign GPIOOUT   = r_gpioout_q;
    assign PARITYERR = r_perr_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_gpio_parity.sv
//------------------------------------------------------------------------------
// Module      : tb_ahb_gpio_parity
// Description : Directed self-checking bench for ahb_gpio_parity.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_gpio_parity;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic        HREADY;
    logic [16:0] GPIOIN;
    logic        PARITYSEL;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [16:0] GPIOOUT;
    logic        PARITYERR;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    ahb_gpio_parity dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .GPIOIN    (GPIOIN),
        .PARITYSEL (PARITYSEL),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .GPIOOUT   (GPIOOUT),
        .PARITYERR (PARITYERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        tick();
    endtask

    task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        tick();
    endtask

    initial begin
        HRESETn = 1'b1; HADDR = 32'h0; HTRANS = 2'b00; HWDATA = 32'h0;
        HWRITE = 1'b0; HSEL = 1'b0; HREADY = 1'b1; GPIOIN = 17'h0; PARITYSEL = 1'b0;
        repeat (5) tick();
        HRESETn = 1'b0;
        tick();

        // Reset state
        check("rst_gpioout", {15'h0, GPIOOUT}, 32'h0);
        check("rst_perr", {31'h0, PARITYERR}, 32'h0);
        check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("idle_hrdata", HRDATA, 32'h0);
        ahb_read(8'h04, rd);
        check("rst_dir", rd, 32'h0);

        // Output mode, parity generation
        ahb_write(8'h04, 32'h0000_0001);
        ahb_read(8'h04, rd);
        check("dir_out", rd, 32'h1);
        ahb_write(8'h00, 32'h0000_A5A5);
        check("a5a5_even", {15'h0, GPIOOUT}, 32'h0000_A5A5);
        PARITYSEL = 1'b1;
        ahb_write(8'h00, 32'h0000_A5A5);
        check("a5a5_odd", {15'h0, GPIOOUT}, 32'h0001_A5A5);
        PARITYSEL = 1'b0;
        ahb_write(8'h00, 32'hFFFF_0001);
        check("0001_even", {15'h0, GPIOOUT}, 32'h0001_0001);
        ahb_read(8'h00, rd);
        check("rd_out_data", rd, 32'h0000_0001);

        // Parity error is suppressed in output mode
        GPIOIN = 17'h01234;
        tick(); tick();
        check("perr_outmode", {31'h0, PARITYERR}, 32'h0);

        // Input mode, parity checking
        ahb_write(8'h04, 32'h0000_0000);
        tick();
        check("perr_bad_even", {31'h0, PARITYERR}, 32'h1);
        GPIOIN = 17'h11234;
        tick();
        check("perr_good_even", {31'h0, PARITYERR}, 32'h0);
        GPIOIN = 17'h01234; PARITYSEL = 1'b1;
        tick();
        check("perr_good_odd", {31'h0, PARITYERR}, 32'h0);
        PARITYSEL = 1'b0;
        ahb_read(8'h00, rd);
        check("rd_in_data", rd, 32'h0000_1234);
        check("hold_on_switch", {15'h0, GPIOOUT}, 32'h0001_0001);

        // Writes ignored in input mode and at unmapped offsets
        ahb_write(8'h00, 32'h0000_FFFF);
        check("in_write_ignored", {15'h0, GPIOOUT}, 32'h0001_0001);
        ahb_write(8'h08, 32'hDEAD_BEEF);
        ahb_read(8'h08, rd);
        check("rd_unmapped", rd, 32'h0);
        ahb_read(8'h04, rd);
        check("dir_in", rd, 32'h0);

        // Transfer with HREADY low is not captured
        ahb_write(8'h04, 32'h0000_0001);
        HREADY = 1'b0;
        ahb_write(8'h04, 32'h0000_0000);
        HREADY = 1'b1;
        ahb_read(8'h04, rd);
        check("hready_low_ignored", rd, 32'h1);

        // Back-to-back write then read of DATA
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        tick();
        HWDATA = 32'h0000_3C3C; HWRITE = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        check("b2b_rd", HRDATA, 32'h0000_3C3C);
        check("b2b_gpioout", {15'h0, GPIOOUT}, 32'h0000_3C3C);
        tick();
        check("idle_after_b2b", HRDATA, 32'h0);

        // Reset in the middle of a transfer discards it
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0000_5555;
        HRESETn = 1'b1;
        tick();
        HRESETn = 1'b0;
        tick();
        check("midrst_gpioout", {15'h0, GPIOOUT}, 32'h0);
        ahb_read(8'h04, rd);
        check("midrst_dir", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_gpio_parity.md
Name: ahb_gpio_parity

Overview:
- AHB-Lite slave GPIO peripheral: one 16-bit GPIO port plus a 17th parity bit (bit 16), selectable as an input or output port.
- In output mode, writes drive the port and a parity bit is generated.
- In input mode, the port is sampled and its parity bit is checked, flagging errors on PARITYERR.
- Sits on the system AHB bus as a single-cycle, zero-wait-state slave.

Parameters:
- None. Data width is fixed at 16 bits plus 1 parity bit.

Ports:
- HCLK input 1: system clock; all state updates on rising edge.
- HRESETn input 1: reset, synchronous, active-high. Asserted high despite the name suffix.
- HADDR input 32: AHB address; only HADDR[7:0] decoded.
- HTRANS input 2: AHB transfer type; HTRANS[1]=1 means NONSEQ/SEQ (valid).
- HWDATA input 32: write data, valid in data phase.
- HWRITE input 1: 1 = write, 0 = read.
- HSEL input 1: slave select.
- HREADY input 1: bus ready; address phase accepted only when high.
- GPIOIN input 17: [15:0] input data, [16] received parity bit.
- PARITYSEL input 1: 0 = even parity, 1 = odd parity.
- HREADYOUT output 1: always 1 (no wait states).
- HRDATA output 32: read data.
- GPIOOUT output 17: [15:0] output data, [16] generated parity bit.
- PARITYERR output 1: registered input-parity error flag.

Behaviour:
- Address phase capture:
  - When HSEL & HREADY & HTRANS[1] are all high at a rising edge, register HADDR[7:0], HWRITE and a valid flag.
  - Otherwise clear the valid flag.
- Register map (HADDR[7:0]):
  - 0x00 DATA.
  - 0x04 DIR: bit0 = 1 output mode, 0 input mode; bits [31:1] read 0.
  - Other offsets: writes ignored, reads return 0.
- Writes: on the rising edge ending the data phase (cycle after capture), update the target register from HWDATA. DIR takes HWDATA[0].
- Write to DATA in output mode:
  - GPIOOUT[15:0] <= HWDATA[15:0].
  - GPIOOUT[16] <= ^HWDATA[15:0] when PARITYSEL=0 (even).
  - GPIOOUT[16] <= ~^HWDATA[15:0] when PARITYSEL=1 (odd).
- Write to DATA in input mode: ignored; GPIOOUT holds.
- Input sampling: every cycle in input mode, datain register <= GPIOIN[15:0].
- Parity check:
  - Every cycle in input mode, PARITYERR <= (GPIOIN[16] != expected).
  - Expected = ^GPIOIN[15:0] (PARITYSEL=0) or ~^GPIOIN[15:0] (PARITYSEL=1).
  - In output mode, PARITYERR <= 0.
- Reads:
  - HRDATA is combinational from the registered address during the data phase.
  - DATA reads {16'h0, datain} in input mode and {16'h0, GPIOOUT[15:0]} in output mode.
  - DIR reads {31'h0, dir}.
  - HRDATA = 0 when no valid read is in its data phase.
- HREADYOUT tied 1; back-to-back transfers supported (pipelined address/data).
- Direction switch:
  - Takes effect the cycle after the DIR write completes.
  - GPIOOUT keeps its last value when switching to input mode.
- Reset (HRESETn=1 at a rising edge):
  - GPIOOUT=0, DIR=0 (input mode), datain=0, PARITYERR=0, captured address/valid cleared.
  - Reset mid-transfer discards the pending transfer.
- IDLE/BUSY (HTRANS[1]=0), HSEL=0 or HREADY=0: no register change.

Test Plan:
- Reset held 5 cycles -> GPIOOUT=17'h0, PARITYERR=0, HREADYOUT=1, read DIR=0.
- Write DIR=1, then write DATA=0x0000_A5A5, PARITYSEL=0 -> GPIOOUT=17'h0A5A5 (8 ones, parity 0); repeat with PARITYSEL=1 -> GPIOOUT=17'h1A5A5.
- Output mode, write DATA=0x0001 (PARITYSEL=0) -> GPIOOUT=17'h10001; read DATA -> HRDATA=0x0000_0001.
- DIR=0, GPIOIN=17'h01234, PARITYSEL=0 (5 ones, parity bit 0 wrong) -> PARITYERR=1 next cycle; GPIOIN=17'h11234 -> PARITYERR=0; read DATA -> 0x0000_1234.
- Input mode, write DATA=0xFFFF -> GPIOOUT unchanged; write to offset 0x08 then read it -> HRDATA=0.
- Back-to-back write DATA/read DATA in output mode with HTRANS=NONSEQ each cycle -> read returns the just-written value, no wait states.
